alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops plus iterative one-bit-per-cycle shifts,
// with a valid/ready handshake on both sides, synchronous flush and asynchronous reset.
module alu_exec_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned SW = $clog2(XLEN);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [1:0]      state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] shifted;
    logic            slt_bit;

    assign shamt   = src_b[SW-1:0];
    assign slt_bit = $signed(src_a) < $signed(src_b);

    always_comb begin
        case (op_q)
            OP_SLL:  shifted = {work_q[XLEN-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work_q[XLEN-1:1]};
            default: shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (!flush && in_valid) begin
                    op_d      = alu_ctrl;
                    illegal_d = 1'b0;
                    state_d   = DONE;
                    case (alu_ctrl)
                        OP_AND: result_d = src_a & src_b;
                        OP_OR:  result_d = src_a | src_b;
                        OP_ADD: result_d = src_a + src_b;
                        OP_SUB: result_d = src_a - src_b;
                        OP_SLT: result_d = {{(XLEN-1){1'b0}}, slt_bit};
                        OP_NOR: result_d = ~(src_a | src_b);
                        OP_SLL, OP_SRL, OP_SRA: begin
                            if (shamt == '0) begin
                                result_d = src_a;
                            end else begin
                                work_d  = src_a;
                                cnt_d   = shamt;
                                state_d = SHIFT;
                            end
                        end
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    work_d = shifted;
                    cnt_d  = cnt_q - SW'(1);
                    // Last step: publish the final shifted value together with entering DONE
                    if (cnt_q == SW'(1)) begin
                        result_d = shifted;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            work_q    <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign illegal   = illegal_q;

endmodule
